// File: rtl/alu_pipe_param.sv
// alu_pipe_param: handshaked, registered ALU with status flags.
// Ops: AND, OR, ADD, SUB, XOR, SLL, SRL, MUL (3-bit opcode).
// Shifts by s>0 and MUL run iteratively, one bit per cycle, in the BUSY state.
// Build option: define ALU_MUL_EN to build the shift-add multiplier. Without it,
// opcode 111 completes in one cycle with out_c=0 and flags {N=0,Z=1,C=1,V=1}.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are both
// high. The producer holds in_a/in_b/in_op stable only while in_valid waits for
// in_ready; out_c/out_flags stay stable while out_valid=1 and out_ready=0.
module alu_pipe_param #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [3:0]       out_flags
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Counter is one bit wider than the shift field so it can also hold WIDTH.
  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic             multi;
  logic             last;

  logic [2:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] work_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res1;
  logic             c1;
  logic             v1;
  logic [3:0]       flags1;

  logic [WIDTH-1:0] work_nxt;
  logic             bit_out;
  logic [WIDTH-1:0] res_b;
  logic             c_b;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_nxt;
`endif

  assign accept = in_valid & in_ready;
  assign shamt  = in_b[SHW-1:0];
  assign last   = (cnt_q == CW'(1));

  // Decide whether the incoming op needs the iterative BUSY path.
  always_comb begin
    multi = ((in_op == OP_SLL) || (in_op == OP_SRL)) && (shamt != '0);
`ifdef ALU_MUL_EN
    if (in_op == OP_MUL) multi = 1'b1;
`endif
  end

  // Single-cycle result and flags, computed straight from the inputs at accept.
  always_comb begin
    sum  = {1'b0, in_a} + {1'b0, in_b};
    diff = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
    res1 = '0;
    c1   = 1'b0;
    v1   = 1'b0;
    case (in_op)
      OP_AND: res1 = in_a & in_b;
      OP_OR:  res1 = in_a | in_b;
      OP_ADD: begin
        res1 = sum[WIDTH-1:0];
        c1   = sum[WIDTH];
        v1   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        res1 = diff[WIDTH-1:0];
        c1   = diff[WIDTH];
        v1   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_XOR: res1 = in_a ^ in_b;
      OP_SLL: res1 = in_a;
      OP_SRL: res1 = in_a;
      OP_MUL: begin
`ifdef ALU_MUL_EN
        res1 = '0;
`else
        res1 = '0;
        c1   = 1'b1;
        v1   = 1'b1;
`endif
      end
      default: res1 = '0;
    endcase
    flags1 = {res1[WIDTH-1], (res1 == '0), c1, v1};
  end

`ifdef ALU_MUL_EN
  // Shift-add step: add the aligned multiplicand when the current multiplier bit is set.
  always_comb begin
    prod_nxt = prod_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
  end
`endif

  // One iteration of the BUSY datapath and the result it would retire on the last step.
  always_comb begin
    if (op_q == OP_SLL) begin
      work_nxt = {work_q[WIDTH-2:0], 1'b0};
      bit_out  = work_q[WIDTH-1];
    end else begin
      work_nxt = {1'b0, work_q[WIDTH-1:1]};
      bit_out  = work_q[0];
    end
    res_b = work_nxt;
    c_b   = bit_out;
`ifdef ALU_MUL_EN
    if (op_q == OP_MUL) begin
      res_b = prod_nxt[WIDTH-1:0];
      c_b   = |prod_nxt[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: accepting in DONE retires the current result at the same edge.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = multi ? BUSY : DONE;
      BUSY: if (last) state_nxt = DONE;
      DONE: begin
        if (accept)         state_nxt = multi ? BUSY : DONE;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: handshake signals are pure functions of state and out_ready.
  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
  end

  // Datapath: capture on accept, iterate while BUSY, register the result when finished.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      cnt_q     <= '0;
      work_q    <= '0;
      out_c     <= '0;
      out_flags <= '0;
`ifdef ALU_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
`endif
    end else if (accept) begin
      op_q   <= in_op;
      work_q <= in_a;
      cnt_q  <= {1'b0, shamt};
`ifdef ALU_MUL_EN
      mcand_q  <= {{WIDTH{1'b0}}, in_a};
      mplier_q <= in_b;
      prod_q   <= '0;
      if (in_op == OP_MUL) cnt_q <= CW'(WIDTH);
`endif
      if (!multi) begin
        out_c     <= res1;
        out_flags <= flags1;
      end
    end else if (state == BUSY) begin
      work_q <= work_nxt;
      cnt_q  <= cnt_q - CW'(1);
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      prod_q   <= prod_nxt;
`endif
      if (last) begin
        out_c     <= res_b;
        out_flags <= {res_b[WIDTH-1], (res_b == '0), c_b, 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_param.sv
// tb_alu_pipe_param: randomized and directed stimulus for alu_pipe_param (WIDTH=8),
// checked against an arithmetic reference model and a timed expected-result queue.
// Honours ALU_MUL_EN the same way as the design.
module tb_alu_pipe_param;

  localparam int W   = 8;
  localparam int SHW = $clog2(W);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   in_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_c;
  logic [3:0]   out_flags;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  bit mon_en = 1'b0;

  // Scoreboard: expected result, flags and the cycle at which out_valid must be seen.
  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_f_q[$];
  int           exp_t_q[$];

  alu_pipe_param #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_flags (out_flags)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Random consumer backpressure when enabled.
  always @(negedge clk) if (rand_ready) out_ready = 1'($urandom_range(0, 1));

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: result, flags {N,Z,C,V} and latency from plain arithmetic.
  function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] r,
                                    output logic [3:0] f, output int lat);
    longint ua, ub, sa, sb, full, md, lim;
    int s;
    bit c, v;
    md   = longint'(1) << W;
    lim  = longint'(1) << (W - 1);
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = (ua >= lim) ? ua - md : ua;
    sb   = (ub >= lim) ? ub - md : ub;
    s    = int'(ub % (longint'(1) << SHW));
    c    = 1'b0;
    v    = 1'b0;
    lat  = 1;
    full = 0;
    case (op)
      3'd0: full = ua & ub;
      3'd1: full = ua | ub;
      3'd2: begin
        full = ua + ub;
        c    = (full >= md);
        v    = (sa + sb >= lim) || (sa + sb < -lim);
      end
      3'd3: begin
        full = ua - ub + md;
        c    = (ua >= ub);
        v    = (sa - sb >= lim) || (sa - sb < -lim);
      end
      3'd4: full = ua ^ ub;
      3'd5: begin
        full = ua << s;
        if (s != 0) begin
          c   = ((ua >> (W - s)) & 1) != 0;
          lat = s + 1;
        end
      end
      3'd6: begin
        full = ua >> s;
        if (s != 0) begin
          c   = ((ua >> (s - 1)) & 1) != 0;
          lat = s + 1;
        end
      end
      default: begin
`ifdef ALU_MUL_EN
        full = ua * ub;
        c    = (full >> W) != 0;
        lat  = W + 1;
`else
        full = 0;
        c    = 1'b1;
        v    = 1'b1;
`endif
      end
    endcase
    r = W'(full % md);
    f = {r[W-1], (r == '0), c, v};
  endfunction

  // Driver: present an op, wait (bounded) for acceptance, then log the expectation.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [3:0]   f;
    int lat, acc_cyc, n;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      return;
    end
    ref_model(op, a, b, r, f, lat);
    acc_cyc = cyc + 1;
    @(posedge clk);
    exp_q.push_back(r);
    exp_f_q.push_back(f);
    exp_t_q.push_back(acc_cyc + lat - 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every cycle compare valid/ready timing and the held result against the queue.
  always @(negedge clk) begin
    bit exp_v, exp_r;
    #1;
    if (rst_n && mon_en) begin
      exp_v = (exp_t_q.size() != 0) && (cyc >= exp_t_q[0]);
      exp_r = (exp_t_q.size() == 0) ? 1'b1 : (exp_v ? out_ready : 1'b0);
      check("out_valid", 32'(out_valid), 32'(exp_v));
      check("in_ready", 32'(in_ready), 32'(exp_r));
      if (exp_v && out_valid) begin
        check("out_c", 32'(out_c), 32'(exp_q[0]));
        check("out_flags", 32'(out_flags), 32'(exp_f_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_f_q.pop_front());
          void'(exp_t_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [2:0] rop;
    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_c", 32'(out_c), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // ADD overflow into the sign bit.
    send(OP_ADD, 8'h7F, 8'h01);
    wait_idle();

    // Back-to-back SUBs while DONE & out_ready.
    send(OP_SUB, 8'h05, 8'h05);
    send(OP_SUB, 8'h03, 8'h05);
    wait_idle();

    // Iterative shift, then a zero-amount shift.
    send(OP_SLL, 8'h81, 8'h03);
    wait_idle();
    send(OP_SRL, 8'h81, 8'h00);
    wait_idle();

    // Multiply, and multiply by zero (no early exit).
    send(OP_MUL, 8'h12, 8'h10);
    wait_idle();
    send(OP_MUL, 8'hAB, 8'h00);
    wait_idle();

    // Boundaries: maximum shift, carry/overflow corners.
    send(OP_SLL, 8'h81, 8'h07);
    wait_idle();
    send(OP_SRL, 8'h81, 8'h07);
    wait_idle();
    send(OP_ADD, 8'hFF, 8'h01);
    send(OP_SUB, 8'h80, 8'h01);
    send(OP_SUB, 8'h7F, 8'hFF);
    wait_idle();

    // Backpressure: result held, new request refused, drop after out_ready.
    out_ready = 1'b0;
    send(OP_AND, 8'hF0, 8'h3C);
    in_op    = OP_XOR;
    in_a     = 8'h11;
    in_b     = 8'h22;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_c", 32'(out_c), 32'h30);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_drop", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Reset in the middle of a multi-cycle operation.
`ifdef ALU_MUL_EN
    send(OP_MUL, 8'h55, 8'h33);
`else
    send(OP_SLL, 8'h55, 8'h07);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_f_q.delete();
    exp_t_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_c", 32'(out_c), 32'd0);
    check("mid_rst_out_flags", 32'(out_flags), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (15) @(negedge clk);

    // Randomized ops with random backpressure and gaps.
    rand_ready = 1'b1;
    repeat (200) begin
      rop = 3'($urandom_range(0, 7));
      send(rop, W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
